// File: rtl/hps_image_port.sv
// ---------------------------------------------------------------------------
// hps_image_port
//
// Bridges the HPS (Avalon-MM slave) to an image-classification accelerator.
// It holds the image RAM that the HPS fills and the accelerator reads. It
// also runs the start/result handshake with a watchdog around each run.
//
// Optional feature: define IMG_PORT_WRITE_LOCK_EN to discard image RAM
// writes while a run is in progress. Each discarded write increments a
// 16-bit saturating error counter, which the HPS reads at ERRCNT. When the
// macro is undefined, image writes always go through, ERRCNT reads 0 and
// the counter is not built.
//
// Ports
//   clk               single clock, rising edge
//   rst_n             asynchronous active-low reset
//   avs_address[8:0]  HPS word address: 0..IMG_WORDS-1 image RAM,
//                     256 CTRL, 257 STATUS, 258 ERRCNT
//   avs_write         HPS write strobe
//   avs_writedata     HPS write data
//   avs_byteenable    byte enables for image RAM writes
//   avs_read          HPS read strobe
//   avs_readdata      HPS read data, one cycle after avs_read
//   image_addr        accelerator byte address; bits [9:2] select the word
//   qsys_readdata     registered image word at image_addr
//   hps_ctrl_pio      bit0 = one-cycle start pulse to the accelerator
//   prediction        accelerator result digit
//   prediction_valid  single-cycle qualifier for prediction
//
// States
//   state   | meaning
//   IDLE    | waiting for a start command
//   RUNNING | accelerator busy; watchdog counting
//   DONE    | result or timeout captured; waiting for restart or ack
// ---------------------------------------------------------------------------
module hps_image_port #(
    parameter int IMG_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [31:0] image_addr,
    output logic [31:0] qsys_readdata,
    output logic [31:0] hps_ctrl_pio,
    input  logic [3:0]  prediction,
    input  logic        prediction_valid
);

    localparam int AW   = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [8:0] ADDR_CTRL   = 9'd256;
    localparam logic [8:0] ADDR_STATUS = 9'd257;
    localparam logic [8:0] ADDR_ERRCNT = 9'd258;
    localparam logic [8:0] IMG_LIMIT   = 9'(IMG_WORDS);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic            start_pulse;
    logic            latch_pred;
    logic            timeout_hit;
    logic            start_q;
    logic            timeout_q;
    logic [3:0]      result_q;
    logic            result_valid_q;
    logic [WD_W-1:0] wd_q;

    logic            ctrl_wr;
    logic            hps_img_sel;
    logic            img_wr_req;
    logic            img_we;
    logic [AW-1:0]   hps_idx;
    logic [AW-1:0]   img_idx;
    logic [15:0]     errcnt_rd;
    logic [31:0]     status_word;
    logic [31:0]     rd_mux;

    logic [31:0] mem [IMG_WORDS];

    // Only the word-select bits of the accelerator address matter.
    logic unused_img_addr_bits;
    assign unused_img_addr_bits = ^{image_addr[31:AW+2], image_addr[1:0]};

    assign hps_idx     = avs_address[AW-1:0];
    assign img_idx     = image_addr[AW+1:2];
    assign hps_img_sel = (avs_address < IMG_LIMIT);
    assign ctrl_wr     = avs_write && (avs_address == ADDR_CTRL);
    assign img_wr_req  = avs_write && hps_img_sel;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_pulse = 1'b0;
        latch_pred  = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_wr && avs_writedata[0]) begin
                    start_pulse = 1'b1;
                    state_d     = RUNNING;
                end
            end
            RUNNING: begin
                // A result arriving on the final watchdog cycle still counts
                // as a good result rather than a timeout.
                if (prediction_valid) begin
                    latch_pred = 1'b1;
                    state_d    = DONE;
                end else if (wd_q == WD_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Restart takes priority over acknowledge when both bits are set.
                if (ctrl_wr && avs_writedata[0]) begin
                    start_pulse = 1'b1;
                    state_d     = RUNNING;
                end else if (ctrl_wr && avs_writedata[1]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog, result and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q        <= 1'b0;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
            result_q       <= 4'h0;
            result_valid_q <= 1'b0;
        end else begin
            start_q <= start_pulse;

            if (start_pulse) begin
                wd_q <= '0;
            end else if ((state_q == RUNNING) && !latch_pred && !timeout_hit) begin
                wd_q <= wd_q + 1'b1;
            end

            if (start_pulse || latch_pred) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end

            if (latch_pred) begin
                result_q <= prediction;
            end

            if (start_pulse) begin
                result_valid_q <= 1'b0;
            end else if (latch_pred) begin
                result_valid_q <= 1'b1;
            end
        end
    end

    assign hps_ctrl_pio = {31'b0, start_q};

    // ------------------------------------------------------------------
    // Optional write lock and error counter
    // ------------------------------------------------------------------
`ifdef IMG_PORT_WRITE_LOCK_EN
    logic        img_locked;
    logic [15:0] errcnt_q;

    assign img_locked = (state_q == RUNNING);
    assign img_we     = img_wr_req && !img_locked;
    assign errcnt_rd  = errcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_q <= 16'h0000;
        end else if (img_wr_req && img_locked && (errcnt_q != 16'hFFFF)) begin
            errcnt_q <= errcnt_q + 16'h0001;
        end
    end
`else
    assign img_we    = img_wr_req;
    assign errcnt_rd = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Image RAM: no reset, so contents survive runs and resets. Reads below
    // sample the array before this write lands, which gives read-before-write
    // on same-word collisions for both read ports.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (img_we) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem[hps_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    assign status_word = {23'b0, result_valid_q, result_q, 1'b0, timeout_q, state_q};

    always_comb begin
        rd_mux = 32'h0;
        if (hps_img_sel) begin
            rd_mux = mem[hps_idx];
        end else begin
            case (avs_address)
                ADDR_STATUS: rd_mux = status_word;
                ADDR_ERRCNT: rd_mux = {16'h0000, errcnt_rd};
                default:     rd_mux = 32'h0;   // CTRL is write-only
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_readdata  <= 32'h0;
            qsys_readdata <= 32'h0;
        end else begin
            qsys_readdata <= mem[img_idx];
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_hps_image_port.sv
module tb_hps_image_port;

    localparam int TO = 16;

`ifdef IMG_PORT_WRITE_LOCK_EN
    localparam logic [31:0] EXP_W7  = 32'h01020304;
    localparam logic [31:0] EXP_ERR = 32'd3;
`else
    localparam logic [31:0] EXP_W7  = 32'hDEADBEEF;
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [31:0] image_addr = '0;
    logic [31:0] qsys_readdata;
    logic [31:0] hps_ctrl_pio;
    logic [3:0]  prediction = '0;
    logic        prediction_valid = 1'b0;

    always #5 clk = ~clk;

    hps_image_port #(.IMG_WORDS(256), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_read         (avs_read),
        .avs_readdata     (avs_readdata),
        .image_addr       (image_addr),
        .qsys_readdata    (qsys_readdata),
        .hps_ctrl_pio     (hps_ctrl_pio),
        .prediction       (prediction),
        .prediction_valid (prediction_valid)
    );

    typedef struct {
        logic [31:0] v;
        string       n;
    } exp_t;

    exp_t q_avs[$];
    exp_t q_img[$];
    exp_t q_pio[$];

    int checks = 0;
    int failures = 0;

    logic qchk = 1'b0;
    logic rd_d = 1'b0;
    logic qc_d = 1'b0;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic push(inout exp_t q[$], input logic [31:0] v, input string n);
        exp_t e;
        e.v = v;
        e.n = n;
        q.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(posedge clk) begin
        rd_d <= avs_read;
        qc_d <= qchk;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_d) begin
            if (q_avs.size() == 0) begin
                checks++; failures++;
                $display("FAIL avs_unexpected: got 0x%08h with no expectation", avs_readdata);
            end else begin
                e = q_avs.pop_front();
                cmp(e.n, avs_readdata, e.v);
            end
        end
        if (qc_d) begin
            if (q_img.size() == 0) begin
                checks++; failures++;
                $display("FAIL img_unexpected: got 0x%08h with no expectation", qsys_readdata);
            end else begin
                e = q_img.pop_front();
                cmp(e.n, qsys_readdata, e.v);
            end
        end
        if (rst_n && hps_ctrl_pio !== 32'h0) begin
            if (q_pio.size() == 0) begin
                checks++; failures++;
                $display("FAIL pio_unexpected: got 0x%08h expected no pulse", hps_ctrl_pio);
            end else begin
                e = q_pio.pop_front();
                cmp(e.n, hps_ctrl_pio, e.v);
            end
        end
    end

    // All tasks are entered at a negedge and return at the following negedge.
    task automatic hps_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_write      = 1'b0;
    endtask

    task automatic hps_read(input logic [8:0] a, input logic [31:0] exp, input string n);
        avs_address = a;
        avs_read    = 1'b1;
        push(q_avs, exp, n);
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    task automatic img_read(input logic [31:0] a, input logic [31:0] exp, input string n);
        image_addr = a;
        qchk       = 1'b1;
        push(q_img, exp, n);
        @(negedge clk);
        qchk       = 1'b0;
    endtask

    task automatic ctrl(input logic [31:0] d, input bit pulse, input string n);
        if (pulse) push(q_pio, 32'h1, n);
        hps_write(9'd256, d, 4'hF);
    endtask

    task automatic pred(input logic [3:0] p);
        prediction       = p;
        prediction_valid = 1'b1;
        @(negedge clk);
        prediction_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        cmp("rst_avs_readdata", avs_readdata, 32'h0);
        cmp("rst_qsys_readdata", qsys_readdata, 32'h0);
        cmp("rst_pio", hps_ctrl_pio, 32'h0);
        rst_n = 1'b1;

        hps_read(9'd257, 32'h0, "status_reset");
        hps_read(9'd258, 32'h0, "errcnt_reset");

        // Image RAM access and byte enables
        hps_write(9'd5, 32'h44332211, 4'hF);
        img_read(32'h14, 32'h44332211, "img_w5_full");
        hps_write(9'd5, 32'hAABBCCDD, 4'h2);
        hps_read(9'd5, 32'h4433CC11, "w5_be2");
        img_read(32'hFFFFFC16, 32'h4433CC11, "img_addr_ignored_bits");

        // Writes to non-RAM addresses must not alias into the RAM
        hps_write(9'd2, 32'h12345678, 4'hF);
        hps_write(9'd258, 32'hCAFEF00D, 4'hF);
        hps_write(9'd257, 32'hFFFFFFFF, 4'hF);
        hps_write(9'd258 + 9'd44, 32'h0BADBEEF, 4'hF);
        hps_read(9'd2, 32'h12345678, "w2_after_dropped");
        hps_read(9'd300, 32'h0, "unmapped_read");
        hps_read(9'd258, 32'h0, "errcnt_after_wr");
        hps_read(9'd257, 32'h0, "status_after_wr");

        // Same-word collision: old word now, new word next read
        avs_address    = 9'd5;
        avs_writedata  = 32'h55667788;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        image_addr     = 32'h14;
        qchk           = 1'b1;
        push(q_img, 32'h4433CC11, "collision_old");
        @(negedge clk);
        avs_write      = 1'b0;
        qchk           = 1'b0;
        img_read(32'h14, 32'h55667788, "collision_new");

        hps_write(9'd7, 32'h01020304, 4'hF);

        // Start, result, ignored late prediction, acknowledge
        ctrl(32'h1, 1, "pio_start1");
        hps_read(9'd257, 32'h001, "status_running");
        pred(4'd7);
        hps_read(9'd257, 32'h172, "status_done_pred");
        pred(4'd9);
        hps_read(9'd257, 32'h172, "pred_outside_running");
        ctrl(32'h2, 0, "");
        hps_read(9'd257, 32'h170, "done_to_idle_keeps_result");

        // Image writes during a run; a second start while running is ignored
        ctrl(32'h1, 1, "pio_start2");
        repeat (3) hps_write(9'd7, 32'hDEADBEEF, 4'hF);
        ctrl(32'h1, 0, "");
        pred(4'd3);
        hps_read(9'd257, 32'h132, "status_done_pred3");
        hps_read(9'd7, EXP_W7, "w7_after_run_writes");
        hps_read(9'd258, EXP_ERR, "errcnt_after_run_writes");

        // Reset in the middle of a run
        ctrl(32'h1, 1, "pio_start3");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        cmp("midrun_rst_pio", hps_ctrl_pio, 32'h0);
        cmp("midrun_rst_readdata", avs_readdata, 32'h0);
        rst_n = 1'b1;
        hps_read(9'd257, 32'h0, "status_after_midrun_rst");
        hps_read(9'd258, 32'h0, "errcnt_after_midrun_rst");
        hps_read(9'd5, 32'h55667788, "ram_persists_reset");

        // Restart from DONE with both bits set; let the watchdog expire
        ctrl(32'h1, 1, "pio_start4");
        pred(4'd2);
        hps_read(9'd257, 32'h122, "status_done_pred2");
        ctrl(32'h3, 1, "pio_start_both_bits");
        repeat (15) @(negedge clk);
        hps_read(9'd257, 32'h021, "wd_last_running_cycle");
        hps_read(9'd257, 32'h026, "wd_timeout_done");

        repeat (3) @(negedge clk);
        checks++;
        if (q_avs.size() != 0 || q_img.size() != 0 || q_pio.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending avs=%0d img=%0d pio=%0d expected 0",
                     q_avs.size(), q_img.size(), q_pio.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hps_image_port.md
HPS_IMAGE_PORT -- requirements
Module: hps_image_port

Interface
REQ-001 Parameter: IMG_WORDS, 256, number of 32-bit image words (1024 8-bit pixels, 4 per word, pixel 0 in bits [7:0]).
REQ-002 Parameter: TIMEOUT_CYCLES, 2000000, number of RUNNING cycles before the watchdog aborts a run.
REQ-003 clk  in  1  single clock; rising edge only.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 avs_address  in  9  HPS word address; 0..IMG_WORDS-1 = image RAM, 256 = CTRL, 257 = STATUS, 258 = ERRCNT.
REQ-006 avs_write  in  1  HPS write strobe, one word per cycle.
REQ-007 avs_writedata  in  32  HPS write data.
REQ-008 avs_byteenable  in  4  per-byte write enable for image RAM writes.
REQ-009 avs_read  in  1  HPS read strobe.
REQ-010 avs_readdata  out  32  HPS read data, valid exactly 1 cycle after avs_read.
REQ-011 image_addr  in  32  accelerator byte address, word-aligned by the consumer; bits [9:2] select the word.
REQ-012 qsys_readdata  out  32  image word at image_addr, registered, 1-cycle latency, always reading.
REQ-013 hps_ctrl_pio  out  32  bit0 = start pulse to the accelerator; bits [31:1] = 0.
REQ-014 prediction  in  4  accelerator predicted digit.
REQ-015 prediction_valid  in  1  single-cycle qualifier for prediction.

Function
REQ-016 FSM states are IDLE, RUNNING, and DONE.
REQ-017 A CTRL write with bit0=1 in IDLE or DONE drives hps_ctrl_pio[0]=1 for exactly one cycle (the cycle after the write) and enters RUNNING.
REQ-018 A CTRL bit0 write in RUNNING is ignored.
REQ-019 In RUNNING, prediction_valid=1 latches prediction into the result register, clears the timeout flag, and enters DONE on the next edge.
REQ-020 In RUNNING, the watchdog counter increments each cycle; on reaching TIMEOUT_CYCLES-1, the block sets the timeout flag and enters DONE.
REQ-021 The watchdog counter is cleared on entry to RUNNING.
REQ-022 A CTRL write with bit1=1 in DONE returns the FSM to IDLE and keeps the result register.
REQ-023 If bit0 and bit1 are both set in one CTRL write, bit0 wins.
REQ-024 prediction_valid outside RUNNING is ignored.
REQ-025 STATUS read layout: [1:0] state (IDLE=0, RUNNING=1, DONE=2), [2] timeout flag, [7:4] result, [8] result_valid (set on latch, cleared on start), all other bits 0.
REQ-026 An image RAM write updates only the bytes whose avs_byteenable bit is set.
REQ-027 Writes to addresses above 258 or to STATUS and ERRCNT are dropped.
REQ-028 Reads of unmapped addresses return 0.
REQ-029 Same-word collision between an HPS write and an accelerator read in one cycle: qsys_readdata returns the old word (read-before-write), and the new word is visible from the next read.
REQ-030 An HPS read of an image word returns the RAM contents, with the same read-before-write rule as REQ-029.
REQ-031 The image RAM has no reset; its contents persist across runs and resets.
REQ-032 image_addr bits [31:10] and [1:0] are ignored.

Reset
REQ-033 rst_n low forces state IDLE, hps_ctrl_pio=0, avs_readdata=0, qsys_readdata=0, result=0, result_valid=0, timeout flag=0, watchdog=0, and ERRCNT=0.
REQ-034 Reset asserted mid-RUNNING aborts the run with no start pulse on release; the first edge after release is IDLE behaviour.

Configuration
REQ-035 Macro IMG_PORT_WRITE_LOCK_EN, when defined: image RAM writes in RUNNING are discarded and ERRCNT (16-bit, saturating at 0xFFFF) increments per discarded write.
REQ-036 When IMG_PORT_WRITE_LOCK_EN is undefined: image writes always proceed, ERRCNT reads 0, and its logic is absent.

Verification
REQ-037 Write word 5 = 0x44332211 with byteenable 0xF, then set image_addr=0x14 -> qsys_readdata=0x44332211 one cycle later.
REQ-038 Write word 5 with byteenable 0x2 and data 0xAABBCCDD -> word 5 reads 0x4433CC11.
REQ-039 CTRL=0x1 in IDLE -> hps_ctrl_pio[0] high for one cycle and STATUS[1:0]=1; then prediction=7 with prediction_valid -> STATUS=0x172.
REQ-040 TIMEOUT_CYCLES=16 with start and no prediction_valid -> DONE after 16 cycles, STATUS[2]=1, STATUS[8]=0.
REQ-041 With the macro defined: 3 image writes during RUNNING -> RAM unchanged and ERRCNT=3; with the macro undefined: RAM updated and ERRCNT=0.
REQ-042 rst_n pulsed low mid-RUNNING -> STATUS=0 and hps_ctrl_pio=0; a following CTRL=0x3 in DONE -> a new run starts.
